vram_arbiter: RTL and testbench

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/mda_pkg.sv | 22 ++
 rtl/vram_arbiter.sv | 162 ++++++++++++++++
 tb/tb_vram_arbiter.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/mda_pkg.sv
// Shared types and defaults for the VRAM arbiter.
package mda_pkg;

    // Arbiter states: one read state per requester plus a three-phase write.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        VID_RD    = 3'd1,
        CPU_RD    = 3'd2,
        WR_SETUP  = 3'd3,
        WR_STROBE = 3'd4,
        WR_HOLD   = 3'd5
    } arb_state_e;

    localparam int RD_CYCLES_DEF = 2;
    localparam int CNT_W         = 3;

    // Read-cycle counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/vram_arbiter.sv
// Single-port SRAM arbiter between the video fetch path and ISA CPU accesses.
// Fixed-latency reads, three-phase writes, alternating priority on contention.
module vram_arbiter
    import mda_pkg::*;
#(
    parameter int RD_CYCLES = RD_CYCLES_DEF,
    parameter int ADDR_W    = 19
) (
    input  logic              clk,
    input  logic              busreset,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_ack,
    output logic [7:0]        vid_rdata,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic              cpu_ack,
    output logic [7:0]        cpu_rdata,
    output logic              cpu_wait,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_we_l,
    output logic [7:0]        ram_dout,
    output logic              ram_doe,
    input  logic [7:0]        ram_din
);

    // Counter value of the last read cycle; ram_din is sampled then.
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_CYCLES - 1);

    arb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last_vid_q, last_vid_d;
    logic [ADDR_W-1:0] ram_a_q, ram_a_d;
    logic              ram_we_l_q, ram_we_l_d;
    logic [7:0]        ram_dout_q, ram_dout_d;
    logic              ram_doe_q, ram_doe_d;
    logic              vid_ack_q, vid_ack_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic [7:0]        vid_rdata_q, vid_rdata_d;
    logic [7:0]        cpu_rdata_q, cpu_rdata_d;
    logic              grant_vid, grant_cpu;

    // Next-state, grant decision and registered SRAM controls.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_vid_d  = last_vid_q;
        ram_a_d     = ram_a_q;
        ram_dout_d  = ram_dout_q;
        ram_we_l_d  = 1'b1;
        ram_doe_d   = 1'b0;
        vid_ack_d   = 1'b0;
        cpu_ack_d   = 1'b0;
        vid_rdata_d = vid_rdata_q;
        cpu_rdata_d = cpu_rdata_q;
        grant_vid   = 1'b0;
        grant_cpu   = 1'b0;

        case (state_q)
            IDLE: begin
                // The ack cycle never grants, so a requester still holding
                // its level request while seeing ack is not served twice.
                if (!vid_ack_q && !cpu_ack_q) begin
                    grant_vid = vid_req && (!cpu_req || !last_vid_q);
                    grant_cpu = cpu_req && !grant_vid;
                end
                if (grant_vid) begin
                    ram_a_d    = vid_addr;
                    cnt_d      = '0;
                    last_vid_d = 1'b1;
                    state_d    = VID_RD;
                end else if (grant_cpu) begin
                    ram_a_d    = cpu_addr;
                    cnt_d      = '0;
                    last_vid_d = 1'b0;
                    if (cpu_we) begin
                        ram_dout_d = cpu_wdata;
                        ram_doe_d  = 1'b1;
                        state_d    = WR_SETUP;
                    end else begin
                        state_d = CPU_RD;
                    end
                end
            end
            VID_RD: begin
                if (cnt_q < RD_LAST) begin
                    cnt_d = sat_inc(cnt_q);
                end else begin
                    vid_rdata_d = ram_din;
                    vid_ack_d   = 1'b1;
                    state_d     = IDLE;
                end
            end
            CPU_RD: begin
                if (cnt_q < RD_LAST) begin
                    cnt_d = sat_inc(cnt_q);
                end else begin
                    cpu_rdata_d = ram_din;
                    cpu_ack_d   = 1'b1;
                    state_d     = IDLE;
                end
            end
            WR_SETUP: begin
                ram_we_l_d = 1'b0;
                ram_doe_d  = 1'b1;
                state_d    = WR_STROBE;
            end
            WR_STROBE: begin
                // Strobe released but data still driven for hold time.
                ram_doe_d = 1'b1;
                state_d   = WR_HOLD;
            end
            WR_HOLD: begin
                cpu_ack_d = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset abandons any access in flight.
    always_ff @(posedge clk) begin
        if (busreset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            last_vid_q  <= 1'b0;
            ram_a_q     <= '0;
            ram_we_l_q  <= 1'b1;
            ram_dout_q  <= '0;
            ram_doe_q   <= 1'b0;
            vid_ack_q   <= 1'b0;
            cpu_ack_q   <= 1'b0;
            vid_rdata_q <= '0;
            cpu_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_vid_q  <= last_vid_d;
            ram_a_q     <= ram_a_d;
            ram_we_l_q  <= ram_we_l_d;
            ram_dout_q  <= ram_dout_d;
            ram_doe_q   <= ram_doe_d;
            vid_ack_q   <= vid_ack_d;
            cpu_ack_q   <= cpu_ack_d;
            vid_rdata_q <= vid_rdata_d;
            cpu_rdata_q <= cpu_rdata_d;
        end
    end

    assign vid_ack   = vid_ack_q;
    assign vid_rdata = vid_rdata_q;
    assign cpu_ack   = cpu_ack_q;
    assign cpu_rdata = cpu_rdata_q;
    assign cpu_wait  = cpu_req && !cpu_ack_q;
    assign ram_a     = ram_a_q;
    assign ram_we_l  = ram_we_l_q;
    assign ram_dout  = ram_dout_q;
    assign ram_doe   = ram_doe_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed self-checking bench for vram_arbiter (RD_CYCLES = 2).
module tb_vram_arbiter;

    localparam int ADDR_W = 19;

    logic              clk = 1'b0;
    logic              busreset;
    logic              vid_req;
    logic [ADDR_W-1:0] vid_addr;
    logic              vid_ack;
    logic [7:0]        vid_rdata;
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [7:0]        cpu_wdata;
    logic              cpu_ack;
    logic [7:0]        cpu_rdata;
    logic              cpu_wait;
    logic [ADDR_W-1:0] ram_a;
    logic              ram_we_l;
    logic [7:0]        ram_dout;
    logic              ram_doe;
    logic [7:0]        ram_din;

    int n_chk = 0;
    int n_pass = 0;

    vram_arbiter #(.RD_CYCLES(2), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .busreset(busreset),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_rdata(vid_rdata),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_wait(cpu_wait),
        .ram_a(ram_a), .ram_we_l(ram_we_l), .ram_dout(ram_dout), .ram_doe(ram_doe),
        .ram_din(ram_din)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // One clock, then sample on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Bounded wait for an ack; n = cycles taken, -1 if the bound expires.
    task automatic wait_ack(input bit is_cpu, input int maxc, output int n);
        n = -1;
        for (int c = 1; c <= maxc; c++) begin
            step();
            if ((is_cpu && cpu_ack) || (!is_cpu && vid_ack)) begin
                n = c;
                break;
            end
        end
    endtask

    initial begin
        int n;
        int we_low, acks, doe_cyc, unstable;
        int v1, v2, cc, vcnt, wait_bad;
        logic [7:0] cpu_rd_seen, vid_rd_mid;

        busreset = 1'b1; vid_req = 1'b0; vid_addr = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        ram_din = 8'h00;
        repeat (3) step();

        // Reset values.
        chk("rst_we_l", ram_we_l, 1);
        chk("rst_doe", ram_doe, 0);
        chk("rst_a", ram_a, 0);
        chk("rst_dout", ram_dout, 0);
        chk("rst_acks", {vid_ack, cpu_ack}, 0);
        chk("rst_rdata", {vid_rdata, cpu_rdata}, 0);
        busreset = 1'b0;
        step();

        // Video read: ack three clocks after request, data A5.
        vid_addr = 19'h00010; ram_din = 8'hA5; vid_req = 1'b1;
        step();
        chk("vrd_a", ram_a, 19'h00010);
        chk("vrd_doe", ram_doe, 0);
        wait_ack(1'b0, 8, n);
        chk("vrd_lat", n + 1, 3);
        chk("vrd_data", vid_rdata, 8'hA5);
        vid_req = 1'b0;
        step();
        chk("vrd_ack_pulse", vid_ack, 0);
        chk("vrd_rdata_hold", vid_rdata, 8'hA5);

        // CPU write: one strobe cycle, address/data stable while driven.
        cpu_addr = 19'h00FA0; cpu_wdata = 8'h41; cpu_we = 1'b1; cpu_req = 1'b1;
        we_low = 0; acks = 0; doe_cyc = 0; unstable = 0; n = -1;
        for (int c = 1; c <= 8; c++) begin
            step();
            if (c == 1) chk("wr_wait", cpu_wait, 1);
            if (!ram_we_l) we_low++;
            if (ram_doe) begin
                doe_cyc++;
                if (ram_a != 19'h00FA0 || ram_dout != 8'h41) unstable++;
            end
            if (!ram_we_l && !ram_doe) unstable++;
            if (cpu_ack) begin
                acks++;
                n = c;
                cpu_req = 1'b0;
                cpu_we = 1'b0;
            end
        end
        chk("wr_we_low", we_low, 1);
        chk("wr_doe_cyc", doe_cyc, 3);
        chk("wr_stable", unstable, 0);
        chk("wr_acks", acks, 1);
        chk("wr_ack_lat", n, 4);

        // Contention: both requests together; video held throughout.
        // Expected order video(3), CPU(7), video(11).
        ram_din = 8'h5A; vid_addr = 19'h00020; cpu_addr = 19'h00030;
        vid_req = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0;
        v1 = 0; v2 = 0; cc = 0; vcnt = 0; wait_bad = 0;
        cpu_rd_seen = '0; vid_rd_mid = '0;
        for (int c = 1; c <= 14; c++) begin
            step();
            if (vid_ack) begin
                vcnt++;
                if (vcnt == 1) begin
                    v1 = c;
                    chk("arb_v1_data", vid_rdata, 8'h5A);
                    ram_din = 8'h3C;
                end else if (vcnt == 2) begin
                    v2 = c;
                    chk("arb_v2_data", vid_rdata, 8'h3C);
                    vid_req = 1'b0;
                end
            end
            if (cpu_ack) begin
                cc = c;
                cpu_rd_seen = cpu_rdata;
                vid_rd_mid = vid_rdata;
                chk("arb_cpu_wait_ack", cpu_wait, 0);
                cpu_req = 1'b0;
            end else if (cc == 0 && !cpu_wait) begin
                wait_bad++;
            end
        end
        chk("arb_v1", v1, 3);
        chk("arb_cpu", cc, 7);
        chk("arb_v2", v2, 11);
        chk("arb_cpu_bound", (cc > 0 && cc <= 8), 1);
        chk("arb_cpu_data", cpu_rd_seen, 8'h3C);
        chk("arb_vid_hold", vid_rd_mid, 8'h5A);
        chk("arb_wait_hi", wait_bad, 0);

        // Reset during the write strobe abandons the write.
        cpu_addr = 19'h00123; cpu_wdata = 8'h77; cpu_we = 1'b1; cpu_req = 1'b1;
        step();
        chk("wrr_setup_doe", ram_doe, 1);
        step();
        chk("wrr_strobe", ram_we_l, 0);
        busreset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0;
        vid_addr = 19'h7FFFF; vid_req = 1'b1;
        step();
        chk("wrr_we_l", ram_we_l, 1);
        chk("wrr_doe", ram_doe, 0);
        chk("wrr_a", ram_a, 0);
        chk("wrr_dout", ram_dout, 0);
        chk("wrr_rdata", {vid_rdata, cpu_rdata}, 0);
        acks = 0;
        if (cpu_ack) acks++;
        step();
        if (cpu_ack) acks++;
        chk("rst_no_grant", ram_a, 0);

        // Held video request is granted from the first cycle after release.
        busreset = 1'b0;
        step();
        if (cpu_ack) acks++;
        chk("rel_a", ram_a, 19'h7FFFF);
        wait_ack(1'b0, 8, n);
        chk("rel_lat", n + 1, 3);
        chk("wrr_no_ack", acks, 0);
        vid_req = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
